// File: rtl/doorlock_pkg.sv
// Shared types and constants for the keypad door-lock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state encoding (3-bit codes), BCD limit, width helpers for timers.
package doorlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Bits needed to hold values 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if (v > (1 << i)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/doorlock_lock_timer.sv
// Shared down-counter used for every timed state of the door lock.
// Latency: load takes effect on the next edge; zero is a registered-value decode.
// Backpressure: none; counter holds at zero until reloaded.
// Ports: clk, rst (sync, active-high), load, value (reload value), zero (count==0).
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// Keypad door-lock controller: framed BCD entry compared against a fixed password.
// Latency: outputs are registered and reflect the new state on the edge that samples a strobe.
// Backpressure: none; keypad strobes are dropped outside IDLE/ENTRY.
// Ports: clk, rst (sync, active-high); ps_start/ps_num/ps_num_valid/ps_end keypad strobes;
//        door_open, state_out, fail_cnt, locked status outputs.
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int          PW_LEN       = 4,
  parameter logic [31:0] PASSWORD     = 32'h0000_1234,
  parameter int          MAX_FAIL     = 3,
  parameter int          OPEN_CYC     = 1000,
  parameter int          FAIL_CYC     = 200,
  parameter int          LOCKOUT_CYC  = 5000,
  parameter int          ENTRY_TO_CYC = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps_start,
  input  logic [3:0] ps_num,
  input  logic       ps_num_valid,
  input  logic       ps_end,
  output logic       door_open,
  output logic [2:0] state_out,
  output logic [3:0] fail_cnt,
  output logic       locked
);

  localparam int BW = 4 * PW_LEN;
  localparam int TW = clog2(max2(max2(OPEN_CYC, FAIL_CYC), max2(LOCKOUT_CYC, ENTRY_TO_CYC)));

  localparam logic [BW-1:0] PW_EXP     = PASSWORD[BW-1:0];
  localparam logic [3:0]    PW_LEN_C   = 4'(PW_LEN);
  localparam logic [3:0]    CNT_MAX    = 4'(PW_LEN + 1);
  localparam logic [3:0]    MAX_FAIL_C = 4'(MAX_FAIL);
  localparam logic [TW-1:0] OPEN_LD    = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] FAIL_LD    = TW'(FAIL_CYC - 1);
  localparam logic [TW-1:0] LOCK_LD    = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] ENTRY_LD   = TW'(ENTRY_TO_CYC - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          bad_q, bad_d;
  logic [3:0]    fail_q, fail_d;
  logic          door_open_q, door_open_d;
  logic          locked_q, locked_d;
  logic [2:0]    state_out_q, state_out_d;

  logic          tmr_reload;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  // Entry contents with the current digit (if any) folded in, so a digit
  // arriving together with ps_end takes part in the compare.
  logic [BW-1:0] buf_nx;
  logic [3:0]    cnt_nx;
  logic          bad_nx;
  logic [3:0]    fail_inc;
  logic          match;

  assign buf_nx   = ps_num_valid ? ((buf_q << 4) | BW'(ps_num)) : buf_q;
  assign cnt_nx   = (ps_num_valid && cnt_q != CNT_MAX) ? cnt_q + 4'd1 : cnt_q;
  assign bad_nx   = bad_q | (ps_num_valid && (ps_num > BCD_MAX));
  assign fail_inc = (fail_q == MAX_FAIL_C) ? fail_q : fail_q + 4'd1;
  assign match    = (cnt_nx == PW_LEN_C) && !bad_nx && (buf_nx == PW_EXP);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    fail_d     = fail_q;
    tmr_reload = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ps_start) begin
          state_d = ST_ENTRY;
          buf_d   = '0;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end
      ST_ENTRY: begin
        if (ps_start) begin
          buf_d      = '0;
          cnt_d      = '0;
          bad_d      = 1'b0;
          tmr_reload = 1'b1;
        end else if (ps_end) begin
          buf_d = buf_nx;
          cnt_d = cnt_nx;
          bad_d = bad_nx;
          if (match) begin
            state_d = ST_OPEN;
            fail_d  = '0;
          end else begin
            fail_d  = fail_inc;
            state_d = (fail_inc == MAX_FAIL_C) ? ST_LOCKOUT : ST_FAIL;
          end
        end else if (ps_num_valid) begin
          buf_d      = buf_nx;
          cnt_d      = cnt_nx;
          bad_d      = bad_nx;
          tmr_reload = 1'b1;
        end else if (tmr_zero) begin
          // Inactivity abort: not counted as a failed attempt.
          state_d = ST_IDLE;
        end
      end
      ST_OPEN, ST_FAIL: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Any state change reloads the timer with the duration of the new state;
  // within ENTRY, digit and restart strobes restart the inactivity window.
  assign tmr_load = (state_d != state_q) || tmr_reload;

  always_comb begin
    case (state_d)
      ST_ENTRY:   tmr_val = ENTRY_LD;
      ST_OPEN:    tmr_val = OPEN_LD;
      ST_FAIL:    tmr_val = FAIL_LD;
      ST_LOCKOUT: tmr_val = LOCK_LD;
      default:    tmr_val = '0;
    endcase
  end

  lock_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  always_comb begin
    door_open_d = (state_d == ST_OPEN);
    locked_d    = (state_d == ST_LOCKOUT);
    state_out_d = state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      fail_q      <= '0;
      door_open_q <= 1'b0;
      locked_q    <= 1'b0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      fail_q      <= fail_d;
      door_open_q <= door_open_d;
      locked_q    <= locked_d;
      state_out_q <= state_out_d;
    end
  end

  assign door_open = door_open_q;
  assign locked    = locked_q;
  assign state_out = state_out_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Self-checking bench for doorlock_ctrl: directed plan cases followed by random keypad traffic,
// every cycle compared against a transaction-level model of the lock.
module tb_doorlock_ctrl;

  localparam int          PW_LEN       = 4;
  localparam logic [31:0] PASSWORD     = 32'h1234;
  localparam int          MAX_FAIL     = 3;
  localparam int          OPEN_CYC     = 8;
  localparam int          FAIL_CYC     = 2;
  localparam int          LOCKOUT_CYC  = 16;
  localparam int          ENTRY_TO_CYC = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps_start = 1'b0;
  logic [3:0] ps_num = 4'd0;
  logic       ps_num_valid = 1'b0;
  logic       ps_end = 1'b0;
  logic       door_open;
  logic [2:0] state_out;
  logic [3:0] fail_cnt;
  logic       locked;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  doorlock_ctrl #(
    .PW_LEN(PW_LEN), .PASSWORD(PASSWORD), .MAX_FAIL(MAX_FAIL),
    .OPEN_CYC(OPEN_CYC), .FAIL_CYC(FAIL_CYC), .LOCKOUT_CYC(LOCKOUT_CYC),
    .ENTRY_TO_CYC(ENTRY_TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .ps_start(ps_start), .ps_num(ps_num),
    .ps_num_valid(ps_num_valid), .ps_end(ps_end), .door_open(door_open),
    .state_out(state_out), .fail_cnt(fail_cnt), .locked(locked)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0..4 (idle/entry/open/fail/lockout), digits typed
  // so far, cycles left in a timed mode, silent cycles seen in entry.
  int m_mode = 0;
  int m_fail = 0;
  int m_left = 0;
  int m_quiet = 0;
  int m_digits[$];

  function automatic int pw_digit(input int i);
    logic [31:0] t;
    t = PASSWORD >> (4 * (PW_LEN - 1 - i));
    return int'(t[3:0]);
  endfunction

  task automatic model_step(input bit st, input bit vld, input bit en, input int num, input bit r);
    bit ok;
    if (r) begin
      m_mode = 0; m_fail = 0; m_left = 0; m_quiet = 0; m_digits.delete();
      return;
    end
    case (m_mode)
      0: if (st) begin m_mode = 1; m_digits.delete(); m_quiet = 0; end
      1: begin
        if (st) begin
          m_digits.delete(); m_quiet = 0;
        end else if (en) begin
          if (vld) m_digits.push_back(num);
          ok = (m_digits.size() == PW_LEN);
          foreach (m_digits[i]) begin
            if (m_digits[i] > 9) ok = 0;
            if (i < PW_LEN && m_digits[i] != pw_digit(i)) ok = 0;
          end
          if (ok) begin
            m_mode = 2; m_left = OPEN_CYC; m_fail = 0;
          end else begin
            if (m_fail < MAX_FAIL) m_fail++;
            if (m_fail == MAX_FAIL) begin m_mode = 4; m_left = LOCKOUT_CYC; end
            else begin m_mode = 3; m_left = FAIL_CYC; end
          end
        end else if (vld) begin
          m_digits.push_back(num); m_quiet = 0;
        end else begin
          m_quiet++;
          if (m_quiet == ENTRY_TO_CYC) m_mode = 0;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (m_mode == 4) m_fail = 0;
          m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic tick(input bit st, input bit vld, input bit en, input logic [3:0] num, input bit r);
    ps_start = st; ps_num_valid = vld; ps_end = en; ps_num = num; rst = r;
    @(posedge clk);
    model_step(st, vld, en, int'(num), r);
    #1;
    check_eq("state_out", 32'(state_out), 32'(m_mode));
    check_eq("door_open", 32'(door_open), 32'(m_mode == 2));
    check_eq("locked",    32'(locked),    32'(m_mode == 4));
    check_eq("fail_cnt",  32'(fail_cnt),  32'(m_fail));
    ps_start = 1'b0; ps_num_valid = 1'b0; ps_end = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 4'd0, 0);
  endtask

  // Types n digits of code (first digit in the highest used nibble), then submits.
  task automatic enter_code(input logic [31:0] code, input int n, input bit merge_end);
    logic [31:0] t;
    tick(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < n; i++) begin
      t = code >> (4 * (n - 1 - i));
      if (merge_end && i == n - 1) tick(0, 1, 1, t[3:0], 0);
      else tick(0, 1, 0, t[3:0], 0);
    end
    if (!merge_end || n == 0) tick(0, 0, 1, 4'd0, 0);
  endtask

  initial begin
    logic [3:0] d;
    int n, kind;
    bit merge;

    tick(0, 0, 0, 4'd0, 1);
    tick(0, 0, 0, 4'd0, 1);
    idle(2);

    enter_code(32'h1234, 4, 0);  idle(10);
    enter_code(32'h1235, 4, 0);  idle(4);
    enter_code(32'h12344, 5, 0); idle(4);
    enter_code(32'h123, 3, 0);   idle(2);
    enter_code(32'h1234, 4, 0);  idle(LOCKOUT_CYC);
    enter_code(32'h1234, 4, 1);  idle(10);
    enter_code(32'h12A4, 4, 0);  idle(4);
    tick(1, 0, 0, 4'd0, 0); tick(0, 1, 0, 4'd1, 0); tick(0, 1, 0, 4'd2, 0);
    enter_code(32'h1234, 4, 0);  idle(10);
    tick(1, 0, 0, 4'd0, 0);      idle(ENTRY_TO_CYC + 3);
    enter_code(32'h1234, 4, 0);  idle(3);
    tick(0, 0, 0, 4'd0, 1);      idle(3);

    for (int ep = 0; ep < 250; ep++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        n = ($urandom_range(0, 1) == 0) ? PW_LEN : $urandom_range(1, 6);
        merge = ($urandom_range(0, 2) == 0);
        tick(1, 0, 0, 4'd0, 0);
        for (int i = 0; i < n; i++) begin
          idle($urandom_range(0, 2));
          if ($urandom_range(0, 15) == 0) tick(1, 0, 0, 4'd0, 0);
          if (i < PW_LEN && $urandom_range(0, 3) != 0) d = 4'(pw_digit(i));
          else d = 4'($urandom_range(0, 15));
          tick(0, 1, merge && (i == n - 1), d, 0);
        end
        if (!merge) begin
          if ($urandom_range(0, 9) == 0) idle(ENTRY_TO_CYC + 1);
          else tick(0, 0, 1, 4'd0, 0);
        end
      end else if (kind < 9) begin
        n = $urandom_range(1, 30);
        for (int j = 0; j < n; j++)
          tick($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), 0);
      end else if ($urandom_range(0, 3) == 0) begin
        tick(0, 0, 0, 4'd0, 1);
      end else begin
        idle($urandom_range(1, 25));
      end
      idle($urandom_range(0, 20));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
